fifo_pack: RTL and testbench

- Byte-to-word packing FIFO. It accepts 8-bit bytes and delivers 16-bit words.
- It is the companion to the 16-to-8 unpacking fifo and performs the reverse width conversion on the return path.
- Both sides use the same valid/enable handshake the team uses on the fifo.
- The first byte received fills data_out[7:0] and the second fills data_out[15:8] (LSB-first).

---
 rtl/fifo_pack.sv | 93 +++++++++
 tb/tb_fifo_pack.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_pack.sv
// Byte-to-word packing FIFO: 8-bit bytes in, 16-bit LSB-first words out.
// Byte-granular write pointer, word-granular read pointer, show-ahead read.
module fifo_pack #(
  parameter  int DEPTH_WORDS = 8,
  localparam int LW          = $clog2(2*DEPTH_WORDS) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          input_valid,
  output logic          input_enable,
  input  logic [7:0]    data_in,
  output logic          output_valid,
  input  logic          output_enable,
  output logic [15:0]   data_out,
  output logic [LW-1:0] level
);

  localparam int CAP = 2 * DEPTH_WORDS;
  localparam int BW  = $clog2(CAP);
  localparam int WW  = $clog2(DEPTH_WORDS);

  localparam logic [LW-1:0] CAP_L = LW'(CAP);
  localparam logic [LW-1:0] TWO_L = LW'(2);

  logic [7:0]    lo_mem [DEPTH_WORDS];
  logic [7:0]    hi_mem [DEPTH_WORDS];

  logic [LW-1:0] count_q, count_d;
  logic [BW-1:0] wr_ptr_q, wr_ptr_d;
  logic [WW-1:0] rd_ptr_q, rd_ptr_d;

  logic          in_fire;
  logic          out_fire;
  logic [WW-1:0] wr_word;
  logic          wr_hi;

  assign input_enable = (count_q < CAP_L);
  assign output_valid = (count_q >= TWO_L);
  assign level        = count_q;

  assign in_fire  = input_valid & input_enable;
  assign out_fire = output_valid & output_enable;

  assign wr_word = wr_ptr_q[BW-1:1];
  assign wr_hi   = wr_ptr_q[0];

  assign data_out = output_valid
                  ? {hi_mem[rd_ptr_q], lo_mem[rd_ptr_q]}
                  : 16'h0000;

  // Power-of-two depth lets both pointers wrap by plain overflow.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (in_fire) begin
      wr_ptr_d = wr_ptr_q + BW'(1);
    end
    if (out_fire) begin
      rd_ptr_d = rd_ptr_q + WW'(1);
    end
    unique case ({in_fire, out_fire})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - TWO_L;
      2'b11:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rstn && in_fire) begin
      if (wr_hi) begin
        hi_mem[wr_word] <= data_in;
      end else begin
        lo_mem[wr_word] <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_fifo_pack.sv
// Self-checking bench for fifo_pack: byte-queue model plus directed vectors.
// The model checks every cycle; literal checks pin the model's arithmetic.
module tb_fifo_pack;

  localparam int DW  = 8;
  localparam int CAP = 2 * DW;
  localparam int LW  = $clog2(CAP) + 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          input_valid;
  logic          input_enable;
  logic [7:0]    data_in;
  logic          output_valid;
  logic          output_enable;
  logic [15:0]   data_out;
  logic [LW-1:0] level;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  logic [7:0] mq [$];

  fifo_pack #(.DEPTH_WORDS(DW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .input_valid   (input_valid),
    .input_enable  (input_enable),
    .data_in       (data_in),
    .output_valid  (output_valid),
    .output_enable (output_enable),
    .data_out      (data_out),
    .level         (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  always @(posedge clk) begin
    bit fi, fo;
    if (!rstn) begin
      mq.delete();
    end else begin
      fi = input_valid && (mq.size() < CAP);
      fo = output_enable && (mq.size() >= 2);
      if (fo) begin
        void'(mq.pop_front());
        void'(mq.pop_front());
      end
      if (fi) mq.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [15:0] ew;
      ew = (mq.size() >= 2) ? {mq[1], mq[0]} : 16'h0000;
      check("m_level", 32'(level), 32'(mq.size()));
      check("m_ie", 32'(input_enable), 32'(mq.size() < CAP));
      check("m_ov", 32'(output_valid), 32'(mq.size() >= 2));
      check("m_dout", 32'(data_out), 32'(ew));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    input_valid = 1'b1;
    data_in     = b;
    tick();
    input_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int cyc;
    logic [15:0] ew;
    rstn          = 1'b0;
    input_valid   = 1'b0;
    output_enable = 1'b0;
    data_in       = 8'h00;
    tick();
    chk_en = 1'b1;
    tick();
    rstn = 1'b1;
    check("rst_level", 32'(level), 0);
    check("rst_ie", 32'(input_enable), 1);
    check("rst_ov", 32'(output_valid), 0);

    push(8'h34);
    check("one_ov", 32'(output_valid), 0);
    push(8'h12);
    check("word_ov", 32'(output_valid), 1);
    check("word_dout", 32'(data_out), 32'h1234);
    check("word_level", 32'(level), 2);
    output_enable = 1'b1;
    tick();
    output_enable = 1'b0;
    check("pop_level", 32'(level), 0);
    check("pop_ov", 32'(output_valid), 0);

    for (int i = 0; i < CAP; i++) push(8'(i));
    check("full_level", 32'(level), 16);
    check("full_ie", 32'(input_enable), 0);
    input_valid = 1'b1;
    data_in     = 8'hFF;
    tick();
    tick();
    check("full_hold", 32'(level), 16);
    check("full_head", 32'(data_out), 32'h0100);
    output_enable = 1'b1;
    tick();
    check("sim1_level", 32'(level), 14);
    check("sim1_head", 32'(data_out), 32'h0302);
    tick();
    input_valid = 1'b0;
    check("sim2_level", 32'(level), 13);
    for (int k = 2; k < DW; k++) begin
      ew = {8'(2*k+1), 8'(2*k)};
      check("drain_word", 32'(data_out), 32'(ew));
      tick();
    end
    output_enable = 1'b0;
    check("drain_level", 32'(level), 1);
    check("drain_ov", 32'(output_valid), 0);

    input_valid   = 1'b1;
    data_in       = 8'h55;
    output_enable = 1'b1;
    rstn          = 1'b0;
    tick();
    tick();
    rstn          = 1'b1;
    input_valid   = 1'b0;
    output_enable = 1'b0;
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_ie", 32'(input_enable), 1);
    check("mid_rst_ov", 32'(output_valid), 0);
    check("mid_rst_dout", 32'(data_out), 0);

    push(8'hAA);
    push(8'hBB);
    push(8'hCC);
    check("odd_head", 32'(data_out), 32'hBBAA);
    output_enable = 1'b1;
    tick();
    output_enable = 1'b0;
    check("odd_level", 32'(level), 1);
    check("odd_ov", 32'(output_valid), 0);
    check("odd_dout", 32'(data_out), 0);
    push(8'hDD);
    check("odd_pair", 32'(data_out), 32'hDDCC);
    output_enable = 1'b1;
    tick();
    output_enable = 1'b0;
    check("odd_empty", 32'(level), 0);

    acc = 0;
    cyc = 0;
    while (acc < 100 && cyc < 2000) begin
      input_valid   = $urandom_range(0, 1) == 1;
      data_in       = 8'($urandom);
      output_enable = $urandom_range(0, 1) == 1;
      if (input_valid && input_enable) acc++;
      tick();
      cyc++;
    end
    input_valid = 1'b0;
    check("rand_accepted", 32'(acc), 100);
    output_enable = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    output_enable = 1'b0;
    check("rand_residue", 32'(level), 0);
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
